// File: rtl/sequenciador_envase.sv
// Bottling-line sequencer: moves each bottle through advance, fill, cork, inspect and exit.
// It also keeps the cork stock and the count of approved bottles in the current dozen.
module sequenciador_envase #(
    parameter int TIMEOUT_ENCHE = 16,
    parameter int TEMPO_VEDA    = 4,
    parameter int REPOR_QTD     = 20,
    parameter int ESTOQUE_INI   = 99
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic       PG,
    input  logic       CH,
    input  logic       CQ,
    input  logic       repor,
    output logic       MOTOR,
    output logic       EV,
    output logic       VE,
    output logic       ALARME,
    output logic [2:0] estado,
    output logic [6:0] estoque,
    output logic [3:0] garrafas,
    output logic       duzia,
    output logic [1:0] causa_alarme
);

    typedef enum logic [2:0] {
        PARADO     = 3'd0,
        AVANCA     = 3'd1,
        ENCHE      = 3'd2,
        VEDA       = 3'd3,
        INSPECIONA = 3'd4,
        SAIDA      = 3'd5,
        EM_ALARME  = 3'd6
    } estado_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_ENCHE);
    localparam logic [7:0] VEDA_LIM    = 8'(TEMPO_VEDA);
    localparam logic [7:0] REPOR_INC   = 8'(REPOR_QTD);
    localparam logic [6:0] ESTOQUE_RST = 7'(ESTOQUE_INI);

    estado_t    estado_q, estado_d;
    logic [7:0] timer_q, timer_d;
    logic [6:0] estoque_q, estoque_d;
    logic [3:0] garrafas_q, garrafas_d;
    logic [1:0] causa_q, causa_d;
    logic       duzia_q, duzia_d;
    logic       motor_q, motor_d;
    logic       ev_q, ev_d;
    logic       ve_q, ve_d;
    logic       alarme_q, alarme_d;
    logic       consome;
    logic [7:0] estoque_soma;

    always_comb begin
        estado_d   = estado_q;
        timer_d    = timer_q;
        garrafas_d = garrafas_q;
        causa_d    = causa_q;
        duzia_d    = 1'b0;
        consome    = 1'b0;

        if (tick) begin
            case (estado_q)
                PARADO: begin
                    if (start) estado_d = AVANCA;
                end
                AVANCA: begin
                    if (!start) begin
                        estado_d = PARADO;
                    end else if (PG) begin
                        estado_d = ENCHE;
                        timer_d  = 8'd0;
                    end
                end
                ENCHE: begin
                    // A full bottle takes priority over the fill timeout on the same tick
                    if (CH) begin
                        if (estoque_q == 7'd0) begin
                            estado_d = EM_ALARME;
                            causa_d  = 2'b10;
                        end else begin
                            estado_d = VEDA;
                            timer_d  = 8'd0;
                            consome  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                        if (timer_q + 8'd1 == TIMEOUT_LIM) begin
                            estado_d = EM_ALARME;
                            causa_d  = 2'b01;
                        end
                    end
                end
                VEDA: begin
                    timer_d = timer_q + 8'd1;
                    if (timer_q + 8'd1 == VEDA_LIM) estado_d = INSPECIONA;
                end
                INSPECIONA: begin
                    if (CQ) begin
                        if (garrafas_q == 4'd11) begin
                            garrafas_d = 4'd0;
                            duzia_d    = 1'b1;
                        end else begin
                            garrafas_d = garrafas_q + 4'd1;
                        end
                    end
                    estado_d = SAIDA;
                end
                SAIDA: begin
                    if (!PG) estado_d = start ? AVANCA : PARADO;
                end
                EM_ALARME: begin
                    if (!start) begin
                        estado_d = PARADO;
                        causa_d  = 2'b00;
                    end
                end
                default: estado_d = PARADO;
            endcase
        end

        // Refill is not tick-gated and can coincide with a cork being consumed
        estoque_soma = {1'b0, estoque_q} + (repor ? REPOR_INC : 8'd0) - (consome ? 8'd1 : 8'd0);
        estoque_d    = (estoque_soma > 8'd99) ? 7'd99 : estoque_soma[6:0];

        motor_d  = (estado_d == AVANCA) || (estado_d == SAIDA);
        ev_d     = (estado_d == ENCHE);
        ve_d     = (estado_d == VEDA);
        alarme_d = (estado_d == EM_ALARME);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q   <= PARADO;
            timer_q    <= 8'd0;
            estoque_q  <= ESTOQUE_RST;
            garrafas_q <= 4'd0;
            causa_q    <= 2'b00;
            duzia_q    <= 1'b0;
            motor_q    <= 1'b0;
            ev_q       <= 1'b0;
            ve_q       <= 1'b0;
            alarme_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            estoque_q  <= estoque_d;
            garrafas_q <= garrafas_d;
            causa_q    <= causa_d;
            duzia_q    <= duzia_d;
            motor_q    <= motor_d;
            ev_q       <= ev_d;
            ve_q       <= ve_d;
            alarme_q   <= alarme_d;
        end
    end

    assign estado       = estado_q;
    assign estoque      = estoque_q;
    assign garrafas     = garrafas_q;
    assign causa_alarme = causa_q;
    assign duzia        = duzia_q;
    assign MOTOR        = motor_q;
    assign EV           = ev_q;
    assign VE           = ve_q;
    assign ALARME       = alarme_q;

endmodule

// File: tb/tb_sequenciador_envase.sv
// Bench for sequenciador_envase: bottle traffic with random timing and quality results,
// compared every clock against a behavioural model of the line, plus scenario checks.
module tb_sequenciador_envase;

    localparam int TIMEOUT_ENCHE = 16;
    localparam int TEMPO_VEDA    = 4;
    localparam int REPOR_QTD     = 20;
    localparam int ESTOQUE_INI   = 99;

    logic       clock = 1'b0;
    logic       reset_n, tick, start, PG, CH, CQ, repor;
    logic       MOTOR, EV, VE, ALARME, duzia;
    logic [2:0] estado;
    logic [6:0] estoque;
    logic [3:0] garrafas;
    logic [1:0] causa_alarme;

    int tests_run    = 0;
    int tests_failed = 0;
    int tick_phase   = 0;
    int ve_clocks    = 0;
    int duzia_pulses = 0;

    int m_estado, m_timer, m_estoque, m_garrafas, m_causa;
    bit m_duzia;

    always #5 clock = ~clock;

    sequenciador_envase #(
        .TIMEOUT_ENCHE(TIMEOUT_ENCHE),
        .TEMPO_VEDA   (TEMPO_VEDA),
        .REPOR_QTD    (REPOR_QTD),
        .ESTOQUE_INI  (ESTOQUE_INI)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tick        (tick),
        .start       (start),
        .PG          (PG),
        .CH          (CH),
        .CQ          (CQ),
        .repor       (repor),
        .MOTOR       (MOTOR),
        .EV          (EV),
        .VE          (VE),
        .ALARME      (ALARME),
        .estado      (estado),
        .estoque     (estoque),
        .garrafas    (garrafas),
        .duzia       (duzia),
        .causa_alarme(causa_alarme)
    );

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Line behaviour at the level of the operator's description: state codes, ticks spent, stock arithmetic
    task automatic model_step();
        int consumo = 0;
        m_duzia = 1'b0;
        if (!reset_n) begin
            m_estado   = 0;
            m_timer    = 0;
            m_estoque  = ESTOQUE_INI;
            m_garrafas = 0;
            m_causa    = 0;
        end else begin
            if (tick) begin
                case (m_estado)
                    0: if (start) m_estado = 1;
                    1: if (!start) m_estado = 0;
                       else if (PG) begin m_estado = 2; m_timer = 0; end
                    2: if (CH && m_estoque == 0) begin m_estado = 6; m_causa = 2; end
                       else if (CH) begin m_estado = 3; m_timer = 0; consumo = 1; end
                       else begin
                           m_timer = m_timer + 1;
                           if (m_timer == TIMEOUT_ENCHE) begin m_estado = 6; m_causa = 1; end
                       end
                    3: begin
                           m_timer = m_timer + 1;
                           if (m_timer == TEMPO_VEDA) m_estado = 4;
                       end
                    4: begin
                           if (CQ) begin
                               m_garrafas = (m_garrafas + 1) % 12;
                               m_duzia = (m_garrafas == 0);
                           end
                           m_estado = 5;
                       end
                    5: if (!PG) m_estado = start ? 1 : 0;
                    6: if (!start) begin m_estado = 0; m_causa = 0; end
                    default: m_estado = 0;
                endcase
            end
            m_estoque = m_estoque + (repor ? REPOR_QTD : 0) - consumo;
            if (m_estoque > 99) m_estoque = 99;
        end
    endtask

    task automatic check_all();
        check_output("estado", 8'(estado), 8'(m_estado));
        check_output("MOTOR", 8'(MOTOR), 8'(m_estado == 1 || m_estado == 5));
        check_output("EV", 8'(EV), 8'(m_estado == 2));
        check_output("VE", 8'(VE), 8'(m_estado == 3));
        check_output("ALARME", 8'(ALARME), 8'(m_estado == 6));
        check_output("estoque", 8'(estoque), 8'(m_estoque));
        check_output("garrafas", 8'(garrafas), 8'(m_garrafas));
        check_output("duzia", 8'(duzia), 8'(m_duzia));
        check_output("causa", 8'(causa_alarme), 8'(m_causa));
    endtask

    task automatic clk_step(input bit rep);
        tick = (tick_phase == 3);
        tick_phase = (tick_phase + 1) % 4;
        repor = rep;
        @(posedge clock);
        model_step();
        @(negedge clock);
        if (VE === 1'b1) ve_clocks++;
        if (duzia === 1'b1) duzia_pulses++;
        check_all();
        repor = 1'b0;
    endtask

    // Runs clocks up to and including the next tick clock; rep raises repor on that tick clock
    task automatic tick_step(input bit rep);
        bit t;
        do begin
            t = (tick_phase == 3);
            clk_step(t ? rep : 1'b0);
        end while (!t);
    endtask

    // One bottle from AVANCA with start held: fill after 'espera' dry ticks, cork, inspect, exit
    task automatic run_bottle(input bit cq, input int espera, input bit rep_fill);
        PG = 1'b1;
        CH = 1'b0;
        tick_step(1'b0);
        repeat (espera) begin
            CQ = 1'($urandom_range(0, 1));
            tick_step(1'b0);
        end
        CH = 1'b1;
        tick_step(rep_fill);
        repeat (TEMPO_VEDA) begin
            CH = 1'($urandom_range(0, 1));
            PG = 1'($urandom_range(0, 1));
            tick_step(1'b0);
        end
        CQ = cq;
        tick_step(1'b0);
        PG = 1'b0;
        CH = 1'b0;
        CQ = 1'($urandom_range(0, 1));
        tick_step(1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            run_bottle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    endtask

    initial begin
        int rejeitada;
        int antes;
        reset_n = 1'b0;
        tick = 1'b0;
        start = 1'b0;
        PG = 1'b0;
        CH = 1'b0;
        CQ = 1'b0;
        repor = 1'b0;

        clk_step(1'b0);
        clk_step(1'b0);
        check_output("rst_estado", 8'(estado), 8'd0);
        check_output("rst_estoque", 8'(estoque), 8'd99);
        check_output("rst_garrafas", 8'(garrafas), 8'd0);
        check_output("rst_lamps", 8'({MOTOR, EV, VE, ALARME, duzia}), 8'd0);
        reset_n = 1'b1;
        clk_step(1'b0);

        // First bottle: states 1,2,3,4,5,1 with corker held for TEMPO_VEDA ticks
        start = 1'b1;
        PG = 1'b1;
        tick_step(1'b0);
        check_output("seq_avanca", 8'(estado), 8'd1);
        tick_step(1'b0);
        check_output("seq_enche", 8'(estado), 8'd2);
        tick_step(1'b0);
        tick_step(1'b0);
        check_output("seq_still_enche", 8'(estado), 8'd2);
        CH = 1'b1;
        ve_clocks = 0;
        tick_step(1'b0);
        check_output("seq_veda", 8'(estado), 8'd3);
        check_output("seq_estoque", 8'(estoque), 8'd98);
        CH = 1'b0;
        repeat (TEMPO_VEDA) tick_step(1'b0);
        check_output("seq_inspeciona", 8'(estado), 8'd4);
        check_output("seq_ve_clocks", 8'(ve_clocks), 8'(TEMPO_VEDA * 4));
        CQ = 1'b1;
        tick_step(1'b0);
        check_output("seq_saida", 8'(estado), 8'd5);
        check_output("seq_garrafas", 8'(garrafas), 8'd1);
        PG = 1'b0;
        tick_step(1'b0);
        check_output("seq_back_avanca", 8'(estado), 8'd1);

        // Fill timeout
        PG = 1'b1;
        tick_step(1'b0);
        repeat (TIMEOUT_ENCHE - 1) tick_step(1'b0);
        check_output("to_not_yet", 8'(ALARME), 8'd0);
        tick_step(1'b0);
        check_output("to_alarme", 8'(ALARME), 8'd1);
        check_output("to_causa", 8'(causa_alarme), 8'd1);
        check_output("to_ev", 8'(EV), 8'd0);
        start = 1'b0;
        tick_step(1'b0);
        check_output("to_parado", 8'(estado), 8'd0);
        check_output("to_causa_clr", 8'(causa_alarme), 8'd0);
        start = 1'b1;
        tick_step(1'b0);

        // Dozen: 12 approved plus one rejected at a random position, count starts at 1
        rejeitada = int'($urandom_range(0, 12));
        duzia_pulses = 0;
        for (int i = 0; i < 13; i++) begin
            antes = int'(garrafas);
            run_bottle(i != rejeitada, int'($urandom_range(0, 3)), 1'b0);
            if (i == rejeitada) check_output("rejected_nochange", 8'(garrafas), 8'(antes));
        end
        check_output("dozen_pulses", 8'(duzia_pulses), 8'd1);
        check_output("dozen_garrafas", 8'(garrafas), 8'd1);
        check_output("dozen_estoque", 8'(estoque), 8'd85);

        // Refill saturation, then refill coinciding with a cork being used
        clk_step(1'b1);
        check_output("repor_85", 8'(estoque), 8'd99);
        drain(9);
        check_output("drain_90", 8'(estoque), 8'd90);
        clk_step(1'b1);
        check_output("repor_90", 8'(estoque), 8'd99);
        drain(89);
        check_output("drain_10", 8'(estoque), 8'd10);
        run_bottle(1'b1, 1, 1'b1);
        check_output("repor_fill_edge", 8'(estoque), 8'd29);
        drain(29);
        check_output("drain_0", 8'(estoque), 8'd0);

        // No cork left
        PG = 1'b1;
        tick_step(1'b0);
        CH = 1'b1;
        tick_step(1'b0);
        check_output("nocork_estado", 8'(estado), 8'd6);
        check_output("nocork_causa", 8'(causa_alarme), 8'd2);
        check_output("nocork_estoque", 8'(estoque), 8'd0);
        CH = 1'b0;
        clk_step(1'b1);
        check_output("nocork_repor", 8'(estoque), 8'd20);
        repeat (3) tick_step(1'b0);
        check_output("nocork_latched", 8'(ALARME), 8'd1);
        start = 1'b0;
        tick_step(1'b0);
        check_output("nocork_parado", 8'(estado), 8'd0);
        check_output("nocork_causa_clr", 8'(causa_alarme), 8'd0);

        // Reset in the middle of corking
        start = 1'b1;
        tick_step(1'b0);
        PG = 1'b1;
        tick_step(1'b0);
        CH = 1'b1;
        tick_step(1'b0);
        tick_step(1'b0);
        check_output("mid_veda", 8'(estado), 8'd3);
        reset_n = 1'b0;
        clk_step(1'b0);
        reset_n = 1'b1;
        check_output("mid_rst_estado", 8'(estado), 8'd0);
        check_output("mid_rst_estoque", 8'(estoque), 8'd99);
        check_output("mid_rst_garrafas", 8'(garrafas), 8'd0);
        check_output("mid_rst_lamps", 8'({MOTOR, EV, VE, ALARME, duzia}), 8'd0);
        check_output("mid_rst_causa", 8'(causa_alarme), 8'd0);
        start = 1'b0;
        PG = 1'b0;
        CH = 1'b0;
        tick_step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
